axi4_wr_arbiter: RTL

Two-requester AXI4 write-channel arbiter that shares one downstream AXI4 write port (AW/W/B) between two burst writers, e.g. the camera frame writer and an overlay/OSD frame writer, ahead of the DDR controller. It grants one complete burst at a time with round-robin priority. It latches the granted address and length, and steers W beats. It generates WLAST from its own beat counter and routes the B response back to the winning requester. Only one write burst is outstanding at any time.

---
 rtl/axi4_wr_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter giving one whole AXI4 write burst at a time to one of two requesters over a shared AW/W/B port.
// AW is registered one cycle after accept, W is passed through combinationally, and B returns to the requester as a one-cycle pulse.
module axi4_wr_arbiter #(
    parameter int C_ID_LEN   = 8,
    parameter int C_DATA_LEN = 128,
    parameter int C_STRB_LEN = C_DATA_LEN/8
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset,
    input  logic [63:0]             s_awaddr,
    input  logic [15:0]             s_awlen,
    input  logic [1:0]              s_awvalid,
    output logic [1:0]              s_awready,
    input  logic [2*C_DATA_LEN-1:0] s_wdata,
    input  logic [1:0]              s_wvalid,
    output logic [1:0]              s_wready,
    input  logic [1:0]              s_wlast,
    output logic [1:0]              s_bvalid,
    output logic [1:0]              s_bresp,
    output logic [C_ID_LEN-1:0]     axi_awid,
    output logic [31:0]             axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [C_DATA_LEN-1:0]   axi_wdata,
    output logic [C_STRB_LEN-1:0]   axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [C_ID_LEN-1:0]     axi_bid,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    output logic [1:0]              grant,
    output logic                    err_wlast
);
    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_pri, r_gidx;
    logic [1:0]  r_grant, r_bvalid, r_bresp;
    logic [31:0] r_awaddr;
    logic [7:0]  r_awlen, r_beat_cnt;
    logic        r_awvalid, r_aw_done, r_w_done, r_err;

    logic w_win, w_accept, w_in_xfer, w_w_open, w_wlast, w_aw_hs, w_beat;
    logic w_aw_done_nxt, w_w_done_nxt, w_b_hs, w_unused;

    // Both requesting: the pointer decides; otherwise the lone requester wins.
    assign w_win         = (&s_awvalid) ? r_pri : s_awvalid[1];
    assign w_in_xfer     = (r_state == ST_XFER);
    assign w_w_open      = w_in_xfer & ~r_w_done;
    assign w_wlast       = w_in_xfer & (r_beat_cnt == r_awlen);
    assign w_aw_hs       = r_awvalid & axi_awready;
    assign w_beat        = w_w_open & s_wvalid[r_gidx] & axi_wready;
    assign w_aw_done_nxt = r_aw_done | w_aw_hs;
    assign w_w_done_nxt  = r_w_done | (w_beat & w_wlast);
    assign w_b_hs        = (r_state == ST_RESP) & axi_bvalid;
    assign w_unused      = ^axi_bid;

    always_ff @(posedge axi_clk) begin
        if (axi_reset) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        s_awready   = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (|s_awvalid) begin
                    w_accept         = 1'b1;
                    s_awready[w_win] = 1'b1;
                    w_state_nxt      = ST_XFER;
                end
            end
            ST_XFER: begin
                // A handshake finishing AW or W in this very cycle still counts.
                if (w_aw_done_nxt & w_w_done_nxt) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (axi_bvalid) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            r_pri      <= 1'b0;
            r_gidx     <= 1'b0;
            r_grant    <= 2'b00;
            r_bvalid   <= 2'b00;
            r_bresp    <= 2'b00;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_beat_cnt <= '0;
            r_awvalid  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_bvalid <= 2'b00;
            if (w_accept) begin
                r_gidx     <= w_win;
                r_grant    <= w_win ? 2'b10 : 2'b01;
                r_awaddr   <= w_win ? s_awaddr[63:32] : s_awaddr[31:0];
                r_awlen    <= w_win ? s_awlen[15:8] : s_awlen[7:0];
                r_awvalid  <= 1'b1;
                r_beat_cnt <= '0;
                r_aw_done  <= 1'b0;
                r_w_done   <= 1'b0;
            end
            if (w_in_xfer && w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (w_wlast) r_w_done <= 1'b1;
                // The requester's own WLAST is only audited; our counter ends the burst.
                if (s_wlast[r_gidx] != w_wlast) r_err <= 1'b1;
            end
            if (w_b_hs) begin
                r_bresp  <= axi_bresp;
                r_bvalid <= r_gidx ? 2'b10 : 2'b01;
                r_grant  <= 2'b00;
                r_pri    <= ~r_gidx;
            end
        end
    end

    assign s_wready    = {w_w_open & axi_wready & r_gidx, w_w_open & axi_wready & ~r_gidx};
    assign s_bvalid    = r_bvalid;
    assign s_bresp     = r_bresp;
    assign axi_awid    = {{(C_ID_LEN-1){1'b0}}, r_gidx};
    assign axi_awaddr  = r_awaddr;
    assign axi_awlen   = r_awlen;
    assign axi_awvalid = r_awvalid;
    assign axi_wdata   = w_in_xfer ? (r_gidx ? s_wdata[2*C_DATA_LEN-1:C_DATA_LEN]
                                             : s_wdata[C_DATA_LEN-1:0]) : '0;
    assign axi_wstrb   = '1;
    assign axi_wlast   = w_wlast;
    assign axi_wvalid  = w_w_open & s_wvalid[r_gidx];
    assign axi_bready  = (r_state == ST_RESP);
    assign grant       = r_grant;
    assign err_wlast   = r_err;
endmodule
